bmem_line_adapter: RTL
======================

Name: bmem_line_adapter

Overview:
Initiator for the burst memory interface. It converts single-cycle cache-line requests from the last-level cache into one fixed-length burst on bmem: read, write, address and write-data. Read beats are assembled into a full line, and write lines are serialized into beats. It sits between the cache's downstream port and the burst memory model or controller, and it is the only bmem master.

Parameters:
LINE_WIDTH, 256, cache line width in bits
BUS_WIDTH, 64, bmem data bus width in bits; LINE_WIDTH must be a multiple of BUS_WIDTH
BURST_LEN, LINE_WIDTH/BUS_WIDTH (4), beats per burst; localparam
TIMEOUT_CYCLES, 4096, stall cycles before the timeout flag sets

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
ufp_addr  in  32  line address; low log2(LINE_WIDTH/8) bits ignored
ufp_read  in  1  line read request, held until ufp_resp
ufp_write  in  1  line write request, held until ufp_resp
ufp_wdata  in  LINE_WIDTH  write line, held until ufp_resp
ufp_rdata  out  LINE_WIDTH  assembled read line, valid when ufp_resp=1
ufp_resp  out  1  one-cycle completion pulse
bmem_addr  out  32  burst base address, line-aligned
bmem_read  out  1  burst read request
bmem_write  out  1  burst write request
bmem_wdata  out  BUS_WIDTH  current write beat
bmem_rdata  in  BUS_WIDTH  read beat
bmem_resp  in  1  beat valid / beat accepted
timeout  out  1  sticky: a burst stalled TIMEOUT_CYCLES cycles with no bmem_resp
proto_err  out  1  sticky: ufp_read and ufp_write were seen together in IDLE

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- While rst=0, all outputs are 0 and the FSM is in IDLE. This applies immediately, including mid-burst; any partial line is discarded.
- FSM states are IDLE, RD, WR and DONE.
- IDLE, ufp_write=1 (write has priority): latch the aligned address and ufp_wdata, set beat cnt=0, go to WR.
- IDLE, ufp_read=1 only: latch the aligned address, set cnt=0, go to RD.
- IDLE, both ufp_read and ufp_write=1: proceed as a write and set proto_err.
- bmem_addr = {ufp_addr[31:5], 5'b0} for a 256-bit line. It is held constant from the first cycle of bmem_read/bmem_write until deassertion.
- bmem_read and bmem_write are never both 1 and are never X after reset.
- RD: bmem_read=1.
  - Each cycle with bmem_resp=1 stores bmem_rdata into line[cnt*BUS_WIDTH +: BUS_WIDTH] and increments cnt.
  - On the beat with cnt=BURST_LEN-1: deassert bmem_read at that same edge and go to DONE.
- WR: bmem_write=1 and bmem_wdata = line[cnt*BUS_WIDTH +: BUS_WIDTH], so beat 0 is driven before the first resp.
  - Each cycle with bmem_resp=1 increments cnt, presenting the next beat for the following edge.
  - On the resp cycle with cnt=BURST_LEN-1: deassert bmem_write and go to DONE.
- DONE: ufp_resp=1 for exactly one cycle, with ufp_rdata = the assembled line (reads). Bus requests are 0. Go to IDLE.
- The minimum gap between bursts is therefore 2 cycles, which gives the memory time to retire its request.
- Read latency: ufp_resp is asserted 1 cycle after the last read beat.
- Write latency: ufp_resp is asserted 1 cycle after the edge that samples the last write beat.
- bmem_resp=1 in IDLE or DONE is ignored; no state change.
- Timeout counter:
  - Resets to 0 on entering RD/WR and on every bmem_resp.
  - Increments each RD/WR cycle without resp, saturating.
  - At TIMEOUT_CYCLES, timeout sets. The burst is not aborted, because aborting would violate the protocol.
- timeout and proto_err clear only on reset.
- ufp_rdata holds its last value outside DONE.
- ufp inputs are sampled only in IDLE; later changes during a burst have no effect.

Test Plan:
- Read, ufp_addr=0x1234_567F, memory beats 0xA0..A3 (64-bit replicated) -> bmem_addr=0x1234_5660 held; bmem_read drops on the 4th resp edge; ufp_resp one cycle later with ufp_rdata={A3,A2,A1,A0}.
- Write, ufp_addr=0x0000_1040, wdata={D3,D2,D1,D0} -> beat D0 presented before the first resp; memory samples D0..D3 in order; bmem_write drops after the 4th resp; single ufp_resp pulse.
- Back-to-back read after write, with the request held through ufp_resp -> bmem_read rises no earlier than 2 cycles after bmem_write falls; no overlap; data correct.
- rst driven low asynchronously mid-read after 2 beats -> bmem_read=0 and ufp_resp=0 without waiting for clk; a following read returns a full correct line.
- ufp_read=ufp_write=1 in IDLE -> write burst issued, proto_err=1 sticky.
- TIMEOUT_CYCLES=16 and memory never responds -> timeout=1 at stall cycle 16; bmem_read still 1; addr unchanged.

Source files
------------

// File: rtl/bmem_line_adapter.sv
// bmem_line_adapter: turns single-cycle cache-line requests into one fixed-length bmem burst.
// Revision 1.0 - initial release.
`default_nettype none

module bmem_line_adapter #(
  parameter int LINE_WIDTH     = 256,
  parameter int BUS_WIDTH      = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           ufp_addr,
  input  logic                  ufp_read,
  input  logic                  ufp_write,
  input  logic [LINE_WIDTH-1:0] ufp_wdata,
  output logic [LINE_WIDTH-1:0] ufp_rdata,
  output logic                  ufp_resp,
  output logic [31:0]           bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BUS_WIDTH-1:0]  bmem_wdata,
  input  logic [BUS_WIDTH-1:0]  bmem_rdata,
  input  logic                  bmem_resp,
  output logic                  timeout,
  output logic                  proto_err
);

  localparam int BURST_LEN = LINE_WIDTH / BUS_WIDTH;
  localparam int CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int OFF_W     = $clog2(LINE_WIDTH / 8);
  localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                 state_q;
  logic [31:0]            addr_q;
  logic [LINE_WIDTH-1:0]  line_q;
  logic [LINE_WIDTH-1:0]  rdata_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [TMO_W-1:0]       tmo_q;
  logic                   resp_q;
  logic                   read_q;
  logic                   write_q;
  logic                   timeout_q;
  logic                   proto_err_q;

  logic [LINE_WIDTH-1:0]  rd_line_d;
  logic [31:0]            aligned_addr_d;
  logic                   unused_addr_bits;

  assign aligned_addr_d   = {ufp_addr[31:OFF_W], {OFF_W{1'b0}}};
  assign unused_addr_bits = ^ufp_addr[OFF_W-1:0];

  // Line with the incoming read beat merged into its slot.
  always_comb begin
    rd_line_d = line_q;
    rd_line_d[cnt_q*BUS_WIDTH +: BUS_WIDTH] = bmem_rdata;
  end

  assign bmem_wdata = (state_q == S_WR) ? line_q[cnt_q*BUS_WIDTH +: BUS_WIDTH] : '0;
  assign bmem_addr  = addr_q;
  assign bmem_read  = read_q;
  assign bmem_write = write_q;
  assign ufp_resp   = resp_q;
  assign ufp_rdata  = rdata_q;
  assign timeout    = timeout_q;
  assign proto_err  = proto_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      line_q      <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      resp_q      <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ufp_write) begin
            addr_q  <= aligned_addr_d;
            line_q  <= ufp_wdata;
            cnt_q   <= '0;
            tmo_q   <= '0;
            write_q <= 1'b1;
            state_q <= S_WR;
            if (ufp_read) begin
              proto_err_q <= 1'b1;
            end
          end else if (ufp_read) begin
            addr_q  <= aligned_addr_d;
            cnt_q   <= '0;
            tmo_q   <= '0;
            read_q  <= 1'b1;
            state_q <= S_RD;
          end
        end
        S_RD: begin
          if (bmem_resp) begin
            line_q <= rd_line_d;
            cnt_q  <= cnt_q + 1'b1;
            tmo_q  <= '0;
            if (cnt_q == CNT_LAST) begin
              read_q  <= 1'b0;
              rdata_q <= rd_line_d;
              resp_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else if (tmo_q != TMO_MAX) begin
            tmo_q <= tmo_q + 1'b1;
            if (tmo_q == TMO_LAST) begin
              timeout_q <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (bmem_resp) begin
            cnt_q <= cnt_q + 1'b1;
            tmo_q <= '0;
            if (cnt_q == CNT_LAST) begin
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else if (tmo_q != TMO_MAX) begin
            // Stalls are flagged but never aborted; the burst must still complete.
            tmo_q <= tmo_q + 1'b1;
            if (tmo_q == TMO_LAST) begin
              timeout_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
